fifo_hs: RTL and testbench

Parametrised synchronous FIFO with valid/ready handshakes on both sides. It supports non-power-of-two depth, an occupancy count, and programmable almost-full/almost-empty flags. Read side is first-word-fall-through: head data is visible whenever pop_valid_o=1. It is the general-purpose buffering block between pipeline stages in the codebase.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_hs.sv | 129 ++++++++++++
 tb/tb_fifo_hs.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for the fifo_hs buffering block.
//   ptr_w(depth) - index width for a DEPTH-entry array, never below 1 bit
//   cnt_w(depth) - width able to hold the occupancy range 0..depth
//   fire_t       - the {push, pop} handshake fire pair for one cycle
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic push;
        logic pop;
    } fire_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: index counter that steps through 0..DEPTH-1 and wraps back to 0.
// DEPTH does not need to be a power of two.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset, forces idx to 0
//   clr   in   synchronous clear, forces idx to 0
//   inc   in   advance the index by one (with wrap) at the edge
//   idx   out  current index
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     inc,
    output logic [ptr_w(DEPTH)-1:0]  idx
);

    localparam int             PW   = ptr_w(DEPTH);
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        if (reset || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= (idx == LAST) ? '0 : idx + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_hs.sv
// fifo_hs: synchronous FIFO with valid/ready handshakes on both sides and a
// first-word-fall-through read port (head data visible while pop_valid_o=1).
// Supports any DEPTH >= 2, an occupancy count and programmable
// almost-full / almost-empty thresholds.
//
// Optional build macro FIFO_FLUSH_EN adds flush_i, a synchronous clear that
// empties the FIFO like reset and overrides any push/pop in that cycle.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   flush_i        in   synchronous clear (only with FIFO_FLUSH_EN)
//   push_valid_i   in   upstream has data
//   push_data_i    in   write payload
//   push_ready_o   out  FIFO can accept (not full)
//   pop_valid_o    out  head entry valid (not empty)
//   pop_data_o     out  head entry payload
//   pop_ready_i    in   downstream accepts head
//   count_o        out  current occupancy
//   full_o         out  count == DEPTH
//   empty_o        out  count == 0
//   almost_full_o  out  count >= AFULL_TH
//   almost_empty_o out  count <= AEMPTY_TH
module fifo_hs
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 8,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef FIFO_FLUSH_EN
    input  logic                     flush_i,
`endif
    input  logic                     push_valid_i,
    input  logic [DATA_W-1:0]        push_data_i,
    output logic                     push_ready_o,
    output logic                     pop_valid_o,
    output logic [DATA_W-1:0]        pop_data_o,
    input  logic                     pop_ready_i,
    output logic [cnt_w(DEPTH)-1:0]  count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o
);

    localparam int             PW       = ptr_w(DEPTH);
    localparam int             CW       = cnt_w(DEPTH);
    localparam logic [CW-1:0]  FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0]  AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0]  AEMPTY_C = CW'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_idx;
    logic [PW-1:0]     wr_idx;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              clr;
    fire_t             fire;

`ifdef FIFO_FLUSH_EN
    assign clr = flush_i;
`else
    assign clr = 1'b0;
`endif

    // Every flag comes straight from the count register, so ready/valid
    // never depend combinationally on the other side's handshake.
    assign full_o         = (count == FULL_C);
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= AFULL_C);
    assign almost_empty_o = (count <= AEMPTY_C);
    assign push_ready_o   = !full_o;
    assign pop_valid_o    = !empty_o;
    assign count_o        = count;

    assign fire.push = push_valid_i && push_ready_o;
    assign fire.pop  = pop_valid_o && pop_ready_i;

    // First-word-fall-through: head entry is read combinationally.
    assign pop_data_o = mem[rd_idx];

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (fire.push),
        .idx   (wr_idx)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (fire.pop),
        .idx   (rd_idx)
    );

    always_comb begin
        // NOTE: defaulting count_next before the case keeps every path
        // assigned, so no latch is inferred.
        count_next = count;
        case ({fire.push, fire.pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // observable through rd_idx/count, which are, and this keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (fire.push && !reset && !clr) begin
            mem[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: tb/tb_fifo_hs.sv
// tb_fifo_hs: self-checking bench for fifo_hs. A DEPTH=4 instance covers
// fill/overflow, concurrent push+pop, full-with-pop, fall-through latency
// and clear during a push; a DEPTH=5 instance covers pointer wrap with a
// non-power-of-two depth. A negedge monitor keeps a queue model per instance
// and checks data order, occupancy, handshakes and flags every cycle.
module tb_fifo_hs;

    logic clk = 1'b0;
    logic reset;

    logic       push_valid4, push_ready4, pop_valid4, pop_ready4;
    logic [7:0] push_data4, pop_data4;
    logic [2:0] count4;
    logic       full4, empty4, af4, ae4, flush4;

    logic       push_valid5, push_ready5, pop_valid5, pop_ready5;
    logic [7:0] push_data5, pop_data5;
    logic [2:0] count5;
    logic       full5, empty5, af5, ae5, flush5;

    int         errors = 0;
    int         checks = 0;
    bit         armed  = 1'b0;
    int         max5   = 0;
    int         pops5  = 0;
    logic [7:0] q4[$];
    logic [7:0] q5[$];

    initial forever #5 clk = ~clk;

    fifo_hs #(.DEPTH(4), .DATA_W(8)) u_dut4 (
        .clk            (clk),
        .reset          (reset),
`ifdef FIFO_FLUSH_EN
        .flush_i        (flush4),
`endif
        .push_valid_i   (push_valid4),
        .push_data_i    (push_data4),
        .push_ready_o   (push_ready4),
        .pop_valid_o    (pop_valid4),
        .pop_data_o     (pop_data4),
        .pop_ready_i    (pop_ready4),
        .count_o        (count4),
        .full_o         (full4),
        .empty_o        (empty4),
        .almost_full_o  (af4),
        .almost_empty_o (ae4)
    );

    fifo_hs #(.DEPTH(5), .DATA_W(8)) u_dut5 (
        .clk            (clk),
        .reset          (reset),
`ifdef FIFO_FLUSH_EN
        .flush_i        (flush5),
`endif
        .push_valid_i   (push_valid5),
        .push_data_i    (push_data5),
        .push_ready_o   (push_ready5),
        .pop_valid_o    (pop_valid5),
        .pop_data_o     (pop_data5),
        .pop_ready_i    (pop_ready5),
        .count_o        (count5),
        .full_o         (full5),
        .empty_o        (empty5),
        .almost_full_o  (af5),
        .almost_empty_o (ae5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: occupancy is the queue size before this cycle's handshakes.
    always @(negedge clk) begin
        int         sz;
        logic [7:0] e;
        if (reset) begin
            q4.delete();
            q5.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (flush4) begin
                q4.delete();
            end else begin
                sz = q4.size();
                check("cnt4",   count4,      sz);
                check("rdy4",   push_ready4, sz < 4);
                check("vld4",   pop_valid4,  sz > 0);
                check("full4",  full4,       sz == 4);
                check("empty4", empty4,      sz == 0);
                check("af4",    af4,         sz >= 3);
                check("ae4",    ae4,         sz <= 1);
                if (pop_ready4 && sz > 0) begin
                    e = q4.pop_front();
                    check("data4", pop_data4, e);
                end
                if (push_valid4 && sz < 4) q4.push_back(push_data4);
            end
            if (flush5) begin
                q5.delete();
            end else begin
                sz = q5.size();
                if (int'(count5) > max5) max5 = int'(count5);
                check("cnt5",   count5,      sz);
                check("rdy5",   push_ready5, sz < 5);
                check("vld5",   pop_valid5,  sz > 0);
                check("full5",  full5,       sz == 5);
                check("af5",    af5,         sz >= 4);
                check("ae5",    ae5,         sz <= 1);
                if (pop_ready5 && sz > 0) begin
                    e = q5.pop_front();
                    pops5++;
                    check("data5", pop_data5, e);
                end
                if (push_valid5 && sz < 5) q5.push_back(push_data5);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] d);
        push_valid4 = 1'b1;
        push_data4  = d;
        step();
        push_valid4 = 1'b0;
    endtask

    task automatic drain4(input string tag);
        int n = 0;
        push_valid4 = 1'b0;
        pop_ready4  = 1'b1;
        while (q4.size() > 0 && n < 20) begin
            step();
            n++;
        end
        pop_ready4 = 1'b0;
        check(tag, q4.size(), 0);
    endtask

    initial begin
        int v;
        int n;
        logic acc;
        logic [7:0] t1 [4];
        t1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

        reset = 1'b1;
        push_valid4 = 1'b0; push_data4 = '0; pop_ready4 = 1'b0; flush4 = 1'b0;
        push_valid5 = 1'b0; push_data5 = '0; pop_ready5 = 1'b0; flush5 = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        check("rst_cnt",   count4,      0);
        check("rst_empty", empty4,      1);
        check("rst_full",  full4,       0);
        check("rst_rdy",   push_ready4, 1);
        check("rst_vld",   pop_valid4,  0);
        check("rst_af",    af4,         0);
        check("rst_ae",    ae4,         1);

        // 1: fill to full, overflow attempt, drain in order
        for (int i = 0; i < 4; i++) begin
            push4(t1[i]);
            if (i == 1) check("t1_af_at2", af4, 0);
            if (i == 2) check("t1_af_at3", af4, 1);
        end
        check("t1_full", full4,       1);
        check("t1_rdy",  push_ready4, 0);
        check("t1_cnt",  count4,      4);
        push4(8'hEE);
        check("t1_cnt_ovf", count4, 4);
        drain4("t1_drain");
        check("t1_empty", empty4, 1);

        // 3: hold at two entries, concurrent push+pop for ten cycles
        push4(8'h11);
        push4(8'h22);
        push_valid4 = 1'b1;
        push_data4  = 8'h55;
        pop_ready4  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_cnt", count4, 2);
        end
        drain4("t3_drain");

        // 4: full FIFO with push and pop together -> only the pop fires
        for (int i = 0; i < 4; i++) push4(8'h61 + 8'(i));
        push_valid4 = 1'b1;
        push_data4  = 8'h65;
        pop_ready4  = 1'b1;
        step();
        push_valid4 = 1'b0;
        pop_ready4  = 1'b0;
        check("t4_cnt", count4,      3);
        check("t4_rdy", push_ready4, 1);
        drain4("t4_drain");

        // 5: empty-FIFO fall-through latency of one cycle
        push_valid4 = 1'b1;
        push_data4  = 8'h3C;
        pop_ready4  = 1'b1;
        check("t5_pre_vld", pop_valid4, 0);
        step();
        push_valid4 = 1'b0;
        check("t5_post_vld",  pop_valid4, 1);
        check("t5_post_data", pop_data4,  8'h3C);
        step();
        pop_ready4 = 1'b0;
        check("t5_empty", empty4, 1);

        // 6: reset with a push in flight discards everything
        push4(8'h71); push4(8'h72); push4(8'h73);
        check("t6_cnt3", count4, 3);
        reset       = 1'b1;
        push_valid4 = 1'b1;
        push_data4  = 8'h99;
        step();
        reset       = 1'b0;
        push_valid4 = 1'b0;
        check("t6_cnt",   count4,     0);
        check("t6_empty", empty4,     1);
        check("t6_ae",    ae4,        1);
        check("t6_vld",   pop_valid4, 0);
        push4(8'h42);
        check("t6_head", pop_data4, 8'h42);
        drain4("t6_drain");

`ifdef FIFO_FLUSH_EN
        push4(8'h81); push4(8'h82); push4(8'h83);
        flush4      = 1'b1;
        push_valid4 = 1'b1;
        push_data4  = 8'h98;
        pop_ready4  = 1'b1;
        step();
        flush4      = 1'b0;
        push_valid4 = 1'b0;
        pop_ready4  = 1'b0;
        check("t6f_cnt",   count4, 0);
        check("t6f_empty", empty4, 1);
        check("t6f_ae",    ae4,    1);
        push4(8'h43);
        check("t6f_head", pop_data4, 8'h43);
        drain4("t6f_drain");
`endif

        // 2: DEPTH=5, twelve values across two pointer wraps
        for (int i = 0; i < 5; i++) begin
            push_valid5 = 1'b1;
            push_data5  = 8'h10 + 8'(i);
            step();
        end
        push_valid5 = 1'b0;
        check("t2_full", full5, 1);
        pop_ready5 = 1'b1;
        v = 5;
        n = 0;
        while (v < 12 && n < 60) begin
            push_valid5 = 1'b1;
            push_data5  = 8'h10 + 8'(v);
            @(negedge clk);
            acc = push_ready5;
            step();
            if (acc) v++;
            n++;
        end
        push_valid5 = 1'b0;
        check("t2_sent", v, 12);
        n = 0;
        while (q5.size() > 0 && n < 20) begin
            step();
            n++;
        end
        pop_ready5 = 1'b0;
        check("t2_drain", q5.size(), 0);
        check("t2_pops",  pops5,     12);
        check("t2_max",   max5 <= 5, 1);
        check("t2_empty", empty5,    1);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
